// File: rtl/dmem_pkg.sv
// Shared address map, STATUS bit positions and region decode for dmem_mmio.
package dmem_pkg;

    localparam logic [31:0] MMIO_BASE   = 32'hFFFF_0000;
    localparam logic [31:0] OFF_CYCLE   = 32'h0000_0000;
    localparam logic [31:0] OFF_CONSOLE = 32'h0000_0004;
    localparam logic [31:0] OFF_STATUS  = 32'h0000_0008;
    localparam logic [31:0] OFF_HALT    = 32'h0000_000C;

    localparam int ST_FULL    = 8;
    localparam int ST_EMPTY   = 9;
    localparam int ST_OVF     = 10;
    localparam int ST_HALTED  = 16;

    typedef enum logic [2:0] {
        RGN_RAM,
        RGN_CYCLE,
        RGN_CONSOLE,
        RGN_STATUS,
        RGN_HALT,
        RGN_NONE
    } region_e;

    // Byte-offset bits are dropped before any comparison.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes);
        logic [31:0] word_addr;
        word_addr = {addr[31:2], 2'b00};
        if (word_addr < ram_bytes) return RGN_RAM;
        case (word_addr)
            MMIO_BASE + OFF_CYCLE:   return RGN_CYCLE;
            MMIO_BASE + OFF_CONSOLE: return RGN_CONSOLE;
            MMIO_BASE + OFF_STATUS:  return RGN_STATUS;
            MMIO_BASE + OFF_HALT:    return RGN_HALT;
            default:                 return RGN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dmem_mmio_console_fifo.sv
// Console output FIFO: registered head, pointers one bit wider than the index,
// and a one-cycle drop flag when a push arrives while full with no pop.
module console_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_count   = r_wptr - r_rptr;
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (o_count == (AW+1)'(DEPTH));
    assign o_valid   = !o_empty;
    assign o_data    = r_mem[r_rptr[AW-1:0]];

    // A simultaneous pop frees the slot, so a push while full still lands.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_drop    = i_push && o_full && !w_do_pop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM plus MMIO window (CYCLE, CONSOLE, STATUS, HALT) for the single-cycle cpu.
// Console FIFO and its STATUS bits exist only when DMEM_CONSOLE_EN is defined.
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int FIFO_DEPTH = 8,
    parameter     INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic        cons_valid,
    output logic [31:0] cons_data,
    input  logic        cons_ready,
    output logic        halted
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_cycle;
    logic          r_halted;
    logic [31:0]   w_status;
    logic [AW-1:0] w_idx;
    region_e       w_region;

    assign w_region = decode_region(daddr, 32'(DEPTH * 4));
    assign w_idx    = daddr[AW+1:2];
    assign halted   = r_halted;

    always_ff @(posedge clk) begin
        if (w_region == RGN_RAM) begin
            for (int i = 0; i < 4; i++) begin
                if (dwe[i]) r_mem[w_idx][8*i +: 8] <= dwdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle  <= '0;
            r_halted <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_region == RGN_HALT && dwe != 4'h0) r_halted <= 1'b1;
        end
    end

`ifdef DMEM_CONSOLE_EN
    localparam int FAW = $clog2(FIFO_DEPTH);

    logic         w_push;
    logic [FAW:0] w_fifo_count;
    logic         w_fifo_full;
    logic         w_fifo_empty;
    logic         w_fifo_drop;
    logic         r_overflow;

    // Only full-word stores reach the console; partial lanes are dropped silently.
    assign w_push = (w_region == RGN_CONSOLE) && (dwe == 4'hF);

    console_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_console_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_data  (dwdata),
        .i_pop   (cons_ready),
        .o_data  (cons_data),
        .o_valid (cons_valid),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_drop  (w_fifo_drop)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_fifo_drop) begin
            r_overflow <= 1'b1;
        end
    end
`else
    logic w_unused;

    assign w_unused   = cons_ready;
    assign cons_valid = 1'b0;
    assign cons_data  = '0;
`endif

    always_comb begin
        w_status = '0;
`ifdef DMEM_CONSOLE_EN
        w_status[7:0]     = 8'(w_fifo_count);
        w_status[ST_FULL] = w_fifo_full;
        w_status[ST_EMPTY] = w_fifo_empty;
        w_status[ST_OVF]  = r_overflow;
`else
        w_status[ST_EMPTY] = 1'b1;
`endif
        w_status[ST_HALTED] = r_halted;
    end

    // Combinational read path: the cpu consumes drdata in the same cycle.
    always_comb begin
        drdata = '0;
        case (w_region)
            RGN_RAM:    drdata = r_mem[w_idx];
            RGN_CYCLE:  drdata = r_cycle;
            RGN_STATUS: drdata = w_status;
            default:    drdata = '0;
        endcase
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Randomized bench for dmem_mmio against a queue/array reference model.
module tb_dmem_mmio;

    localparam int DEPTH = 64;
    localparam int FD    = 8;
    localparam logic [31:0] A_CYCLE   = 32'hFFFF_0000;
    localparam logic [31:0] A_CONSOLE = 32'hFFFF_0004;
    localparam logic [31:0] A_STATUS  = 32'hFFFF_0008;
    localparam logic [31:0] A_HALT    = 32'hFFFF_000C;
    localparam logic [31:0] A_IDLE    = 32'h4000_0000;
`ifdef DMEM_CONSOLE_EN
    localparam bit CONS_EN = 1'b1;
`else
    localparam bit CONS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;
    logic        cons_valid;
    logic [31:0] cons_data;
    logic        cons_ready;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    logic [31:0] m_cyc;
    logic [31:0] m_q [$];
    bit          m_ovf;
    bit          m_halt;

    dmem_mmio #(
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (FD),
        .INIT_FILE  ("")
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .daddr      (daddr),
        .dwdata     (dwdata),
        .dwe        (dwe),
        .drdata     (drdata),
        .cons_valid (cons_valid),
        .cons_data  (cons_data),
        .cons_ready (cons_ready),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ram_unknown(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w < DEPTH * 4) return !m_known[w >> 2];
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] st;
        w = a & 32'hFFFF_FFFC;
        if (w < DEPTH * 4) return m_mem[w >> 2];
        if (w == A_CYCLE) return m_cyc;
        if (w == A_STATUS) begin
            st = m_halt ? 32'h0001_0000 : 32'h0;
            if (CONS_EN) begin
                st = st + m_q.size();
                if (m_q.size() == FD) st = st + 32'h100;
                if (m_q.size() == 0)  st = st + 32'h200;
                if (m_ovf)            st = st + 32'h400;
            end else begin
                st = st + 32'h200;
            end
            return st;
        end
        return 32'h0;
    endfunction

    // Drive one cycle at the falling edge, check outputs, then advance the model.
    task automatic step(input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] we, input logic rdy);
        logic [31:0] w;
        bit          pop;
        bit          push;
        daddr = a; dwdata = wd; dwe = we; cons_ready = rdy;
        #1;
        if (!ram_unknown(a)) check("rdata", drdata, model_read(a));
        check("halted", {31'b0, halted}, {31'b0, m_halt});
        check("cons_valid", {31'b0, cons_valid}, {31'b0, m_q.size() != 0});
        if (m_q.size() != 0)  check("cons_data", cons_data, m_q[0]);
        else if (!CONS_EN)    check("cons_data_tied", cons_data, 32'h0);
        w    = a & 32'hFFFF_FFFC;
        pop  = (m_q.size() != 0) && rdy;
        push = CONS_EN && (w == A_CONSOLE) && (we == 4'hF);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < FD) m_q.push_back(wd);
            else                 m_ovf = 1'b1;
        end
        if (w < DEPTH * 4) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) m_mem[w >> 2][8*i +: 8] = wd[8*i +: 8];
            end
            if (we == 4'hF) m_known[w >> 2] = 1'b1;
        end
        if (w == A_HALT && we != 4'h0) m_halt = 1'b1;
        m_cyc = m_cyc + 32'd1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        daddr = A_IDLE; dwe = 4'h0; cons_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_halted", {31'b0, halted}, 32'h0);
        check("rst_cons_valid", {31'b0, cons_valid}, 32'h0);
        reset = 1'b1;
        m_q.delete();
        m_ovf  = 1'b0;
        m_halt = 1'b0;
        @(negedge clk);
        m_cyc = 32'd1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  we;
        int          r;

        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        m_cyc = '0; m_ovf = 1'b0; m_halt = 1'b0;
        reset = 1'b0; daddr = A_STATUS; dwdata = '0; dwe = 4'h0; cons_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_status", drdata, 32'h0000_0200);
        check("rst_halted0", {31'b0, halted}, 32'h0);
        check("rst_valid0", {31'b0, cons_valid}, 32'h0);
        daddr = A_CYCLE;
        #1 check("rst_cycle", drdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Cycle counter: ten edges after release reads 10, then forced wrap.
        for (int i = 0; i < 10; i++) step(A_CYCLE, 32'h0, 4'h0, 1'b0);
        daddr = A_CYCLE;
        #1 check("cycle_10", drdata, 32'd10);
        @(negedge clk);
        force dut.r_cycle = 32'hFFFF_FFFF;
        #1 release dut.r_cycle;
        #1 check("cycle_max", drdata, 32'hFFFF_FFFF);
        @(negedge clk);
        #1 check("cycle_wrap", drdata, 32'h0);
        m_cyc = 32'h0;
        @(negedge clk);
        m_cyc = 32'h1;

        for (int i = 0; i < DEPTH; i++) step(32'(i * 4), $urandom, 4'hF, 1'b0);

        // Byte lanes.
        step(32'h10, 32'hAABB_CCDD, 4'hF, 1'b0);
        step(32'h11, 32'h1122_3344, 4'b0101, 1'b0);
        daddr = 32'h12; dwe = 4'h0;
        #1 check("byte_lanes", drdata, 32'hAA22_CC44);
        @(negedge clk); m_cyc = m_cyc + 1;

        // Unmapped and beyond-RAM addresses.
        step(32'h8000_0000, $urandom, 4'hF, 1'b0);
        daddr = 32'h8000_0000; dwe = 4'h0;
        #1 check("unmapped_rd", drdata, 32'h0);
        @(negedge clk); m_cyc = m_cyc + 1;
        step(32'h0, 32'h0, 4'h0, 1'b0);
        step(32'(DEPTH * 4), $urandom, 4'hF, 1'b0);
        step(32'(DEPTH * 4), 32'h0, 4'h0, 1'b0);
        step(32'h0, 32'h0, 4'h0, 1'b0);

        // Console: overfill, drain, then push+pop while full.
        for (int k = 1; k <= 9; k++) step(A_CONSOLE, 32'(k), 4'hF, 1'b0);
        daddr = A_STATUS; dwe = 4'h0;
        #1 check("status_full", drdata, CONS_EN ? 32'h0000_0508 : 32'h0000_0200);
        @(negedge clk); m_cyc = m_cyc + 1;
        for (int k = 0; k < 10; k++) step(A_STATUS, 32'h0, 4'h0, 1'b1);
        daddr = A_STATUS;
        #1 check("status_empty", {31'b0, drdata[9]}, 32'h1);
        @(negedge clk); m_cyc = m_cyc + 1;
        step(A_CONSOLE, 32'h77, 4'b0111, 1'b0);
        for (int k = 1; k <= 8; k++) step(A_CONSOLE, 32'(100 + k), 4'hF, 1'b0);
        step(A_CONSOLE, 32'h55, 4'hF, 1'b1);
        daddr = A_STATUS; dwe = 4'h0;
        #1 check("full_push_pop", drdata, CONS_EN ? 32'h0000_0508 : 32'h0000_0200);
        @(negedge clk); m_cyc = m_cyc + 1;
        for (int k = 0; k < 9; k++) step(A_STATUS, 32'h0, 4'h0, 1'b1);

        // Randomized mix.
        for (int n = 0; n < 300; n++) begin
            r  = $urandom_range(0, 9);
            wd = $urandom;
            we = 4'h0;
            a  = A_IDLE;
            case (r)
                0, 1, 2, 3: begin
                    a  = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
                    we = 4'($urandom_range(0, 15));
                end
                4: a = 32'($urandom_range(0, DEPTH * 4 - 1));
                5: begin
                    a  = A_CONSOLE;
                    we = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
                end
                6: a = A_STATUS;
                7: a = A_CYCLE;
                8: begin
                    a  = $urandom | 32'h8000_0000;
                    if (a[31:4] == 28'hFFFF_000) a = a ^ 32'h0000_0100;
                    we = 4'($urandom_range(0, 15));
                end
                default: a = ($urandom_range(0, 1) == 0) ? A_CONSOLE : A_HALT;
            endcase
            step(a, wd, we, 1'($urandom_range(0, 1)));
        end

        // Halt, then asynchronous reset between edges.
        step(A_HALT, $urandom, 4'($urandom_range(1, 15)), 1'b0);
        daddr = A_IDLE; dwe = 4'h0;
        #1 check("halt_set", {31'b0, halted}, 32'h1);
        @(negedge clk); m_cyc = m_cyc + 1;
        step(A_STATUS, 32'h0, 4'h0, 1'b0);
        for (int k = 0; k < 3; k++) step(A_CONSOLE, $urandom, 4'hF, 1'b0);
        reset_pulse();
        step(A_CYCLE, 32'h0, 4'h0, 1'b0);
        step(A_STATUS, 32'h0, 4'h0, 1'b0);
        for (int k = 0; k < 6; k++) step(32'($urandom_range(0, DEPTH - 1) * 4), 32'h0, 4'h0, 1'b1);
        step(32'h10, 32'h0, 4'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
